// File: rtl/instr_fetch_unit.sv
// Fetch stage: one imem read per PC, delivers the word to decode; best case 4 cycles/instr.
// Backpressure: holds the request until imem ready, holds instr until decode ready; flush drains.
module instr_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_enable,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        ADV,
        DRAIN,
        FAULT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] addr_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] instr_pc_nxt;
    logic        instr_valid_nxt;
    logic        fault_nxt;
    logic        pc_misaligned;

    assign pc_misaligned = (pc[1:0] != 2'b00);

    // A misaligned PC never reaches memory; the FSM parks in FAULT instead.
    assign imem_req_valid = (state == REQ) && !pc_misaligned;
    assign imem_addr      = (state == REQ) ? pc : addr_q;

    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr_q;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        fault_nxt       = fetch_fault;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (pc_misaligned) begin
                    fault_nxt = 1'b1;
                    state_nxt = FAULT;
                end else if (imem_req_ready) begin
                    addr_nxt  = pc;
                    state_nxt = flush ? DRAIN : WAIT;
                end else if (flush) begin
                    state_nxt = ADV;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush) begin
                        state_nxt = ADV;
                    end else begin
                        instr_nxt       = imem_rsp_data;
                        instr_pc_nxt    = addr_q;
                        instr_valid_nxt = 1'b1;
                        state_nxt       = HOLD;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                // Flush wins over a simultaneous decode accept.
                if (flush) begin
                    instr_valid_nxt = 1'b0;
                    instr_nxt       = NOP_INSTR;
                    state_nxt       = ADV;
                end else if (instr_ready) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ADV;
                end
            end
            ADV: state_nxt = REQ;
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt = ADV;
                end
            end
            FAULT: begin
                if (flush) begin
                    fault_nxt = 1'b0;
                    state_nxt = ADV;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= 32'h0;
            pc_enable   <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr_q      <= addr_nxt;
            pc_enable   <= (state_nxt == ADV);
            instr_valid <= instr_valid_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            fetch_fault <= fault_nxt;
        end
    end

endmodule
